// File: rtl/dmem_responder.sv
// Data memory responder: 1024x64 array behind a 2-entry store buffer with load forwarding
// and a halt/drain FSM. Define DMEM_BOUNDS_CHECK_EN to reject accesses to word 1023.
module dmem_responder (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [63:0] mem_data,
  input  logic        mem_rw,
  input  logic        mem_re,
  input  logic [12:0] mem_addr,
  input  logic        halt,
  output logic        drained,
  output logic [1:0]  wb_count,
  output logic        addr_err
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t      state, state_next;
  logic [63:0] mem [1024];

  // Entry 0 is always the oldest; entry 1 is only valid when entry 0 is.
  logic        v0, v1, v0_next, v1_next;
  logic [9:0]  idx0, idx1, idx0_next, idx1_next;
  logic [63:0] dat0, dat1, dat0_next, dat1_next;

  logic [9:0]  word;
  logic        in_range, store, idle, hit0, hit1, mem_we, drive;
  logic [63:0] rdata;
  logic        unused_bits;

  assign word        = mem_addr[12:3];
  assign unused_bits = ^mem_addr[2:0];
`ifdef DMEM_BOUNDS_CHECK_EN
  assign in_range = (word != 10'h3ff);
`else
  assign in_range = 1'b1;
`endif

  assign store    = mem_rw && in_range;
  assign idle     = !mem_rw && !mem_re;
  assign hit0     = v0 && (idx0 == word);
  assign hit1     = v1 && (idx1 == word);
  assign wb_count = {v0 & v1, v0 ^ v1};
  assign drained  = (state == DONE);

  always_comb begin
    state_next = state;
    v0_next    = v0;
    v1_next    = v1;
    idx0_next  = idx0;
    idx1_next  = idx1;
    dat0_next  = dat0;
    dat1_next  = dat1;
    mem_we     = 1'b0;
    case (state)
      RUN: begin
        // The halt edge only changes state; the buffer is frozen for that cycle.
        if (halt) begin
          state_next = (wb_count == 2'd0) ? DONE : DRAIN;
        end else if (store) begin
          if (hit1) begin
            dat1_next = mem_data;
          end else if (hit0) begin
            dat0_next = mem_data;
          end else if (!v0) begin
            v0_next   = 1'b1;
            idx0_next = word;
            dat0_next = mem_data;
          end else if (!v1) begin
            v1_next   = 1'b1;
            idx1_next = word;
            dat1_next = mem_data;
          end else begin
            mem_we    = 1'b1;
            idx0_next = idx1;
            dat0_next = dat1;
            idx1_next = word;
            dat1_next = mem_data;
          end
        end else if (idle && v0) begin
          mem_we    = 1'b1;
          v0_next   = v1;
          idx0_next = idx1;
          dat0_next = dat1;
          v1_next   = 1'b0;
        end
      end
      DRAIN: begin
        if (v0) begin
          mem_we    = 1'b1;
          v0_next   = v1;
          idx0_next = idx1;
          dat0_next = dat1;
          v1_next   = 1'b0;
        end
        if (!v1) state_next = DONE;
      end
      default: state_next = DONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      v0    <= 1'b0;
      v1    <= 1'b0;
      idx0  <= '0;
      idx1  <= '0;
      dat0  <= '0;
      dat1  <= '0;
    end else begin
      state <= state_next;
      v0    <= v0_next;
      v1    <= v1_next;
      idx0  <= idx0_next;
      idx1  <= idx1_next;
      dat0  <= dat0_next;
      dat1  <= dat1_next;
    end
  end

  // Array has no reset; commits always take the oldest entry.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx0] <= dat0;
  end

  always_comb begin
    if (hit1)      rdata = dat1;
    else if (hit0) rdata = dat0;
    else           rdata = mem[word];
`ifdef DMEM_BOUNDS_CHECK_EN
    if (!in_range) rdata = '0;
`endif
  end

  assign drive    = rst && mem_re && !mem_rw;
  assign mem_data = drive ? rdata : 64'bz;

`ifdef DMEM_BOUNDS_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) addr_err <= 1'b0;
    else if ((mem_rw || mem_re) && !in_range) addr_err <= 1'b1;
  end
`else
  assign addr_err = 1'b0;
`endif

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-003 SHALL have port mem_data, inout, 64, shared data bus: driven by the CPU on stores, driven by this block on loads, Z otherwise.
REQ-004 SHALL have port mem_rw, input, 1, store strobe; 1 = CPU is driving mem_data this cycle.
REQ-005 SHALL have port mem_re, input, 1, load strobe; 1 = block drives read data this cycle.
REQ-006 SHALL have port mem_addr, input, 13, byte address; word index = mem_addr[12:3], bits [2:0] ignored.
REQ-007 SHALL have port halt, input, 1, CPU halt indication; level, sampled each clk.
REQ-008 SHALL have port drained, output, 1, 1 = halt seen and write buffer fully committed.
REQ-009 SHALL have port wb_count, output, 2, current write-buffer occupancy (0..2).
REQ-010 SHALL have port addr_err, output, 1, sticky out-of-range access flag.

Function
REQ-011 SHALL hold a 1024 x 64-bit storage array with one write port; reads are combinational.
REQ-012 SHALL hold a 2-entry FIFO write buffer; each entry is valid, word index and 64-bit data.
REQ-013 SHALL enqueue {mem_addr[12:3], mem_data} at the clk edge ending any cycle with mem_rw=1.
REQ-014 SHALL drain the oldest entry to the array only in a cycle with mem_rw=0 and mem_re=0 (idle cycle), one entry per cycle.
REQ-015 SHALL, on a store while wb_count=2, drain the oldest entry and enqueue the new one at the same edge; wb_count stays 2 and no store is lost.
REQ-016 SHALL drive mem_data combinationally, in the same cycle, when mem_re=1 and mem_rw=0; zero added latency.
REQ-017 SHALL return, for a load, the data of the newest valid buffer entry whose word index matches; otherwise the array word.
REQ-018 SHALL treat mem_rw=1 with mem_re=1 as a store; the block does not drive the bus in that cycle.
REQ-019 SHALL update a buffer entry in place when a store hits the same word index as a valid entry; no new entry is allocated and occupancy does not change.
REQ-020 SHALL run the FSM RUN -> DRAIN when halt=1 is sampled; DRAIN -> DONE at the edge where wb_count becomes 0; DONE holds until reset.
REQ-021 SHALL, in DRAIN, commit one entry per cycle regardless of strobes, and ignore new stores.
REQ-022 SHALL go directly RUN -> DONE if halt=1 is sampled while wb_count=0; drained=1 only in DONE.

Reset
REQ-023 SHALL, while rst=0, clear all buffer valid bits and set wb_count=0, drained=0, addr_err=0, FSM=RUN, and release mem_data to Z.
REQ-024 SHALL NOT reset array contents; stores pending in the buffer when reset is asserted are discarded.
REQ-025 SHALL leave all state unchanged at the first clk edge after rst deasserts if strobes are low.

Configuration
REQ-026 SHALL, with macro DMEM_BOUNDS_CHECK_EN defined, treat byte addresses >= 8184 as out of range: such stores are dropped, such loads return 0, and addr_err is set sticky at the next edge.
REQ-027 SHALL, without DMEM_BOUNDS_CHECK_EN, wrap every address modulo 1024 words and tie addr_err to 0.

Verification
REQ-028 SHALL cover: reset, store 0xDEADBEEF_00000001 @0x008, then load @0x008 in the next cycle -> load returns the forwarded value and wb_count=1.
REQ-029 SHALL cover: stores @0x010 and @0x018 on back-to-back cycles, then a third store @0x020 -> wb_count=2 and the @0x010 value is in the array; a load of each address returns the correct value.
REQ-030 SHALL cover: a store to @0x030 with value A, then a store to @0x030 with value B -> wb_count=1 and a load of @0x030 returns B.
REQ-031 SHALL cover: wb_count=2, then halt=1 -> DRAIN for 2 cycles, drained=1 on the 3rd edge, and both values are in the array.
REQ-032 SHALL cover: mem_rw=1 and mem_re=1 together -> the block never drives mem_data (no bus contention); reset asserted mid-DRAIN -> drained=0 and wb_count=0 immediately.
REQ-033 SHALL cover, with DMEM_BOUNDS_CHECK_EN defined: a load at 0x1FF8 -> returns 0 and addr_err=1 at the next edge.
